simplez_sequencer: RTL and testbench



---
 rtl/simplez_sequencer_if.sv | 30 +++
 rtl/simplez_sequencer.sv | 60 ++++++
 tb/tb_simplez_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/simplez_sequencer_if.sv
// simplez_sequencer_if: opcode/flag inputs and micro-order outputs between sequencer and datapath
interface simplez_sequencer_if;
  logic [2:0] co;
  logic       z;
  logic       cont;
  logic       lec;
  logic       esc;
  logic       era;
  logic       incp;
  logic       ccp;
  logic       scp;
  logic       eri;
  logic       sri;
  logic       eac;
  logic       sac;
  logic       sum;
  logic       tra2;
  logic       dec1;
  logic       clr;
  logic       stop;
  logic [2:0] state;
  modport slave (
    input  co, z, cont,
    output lec, esc, era, incp, ccp, scp, eri, sri, eac, sac, sum, tra2, dec1, clr, stop, state
  );
  modport master (
    output co, z, cont,
    input  lec, esc, era, incp, ccp, scp, eri, sri, eac, sac, sum, tra2, dec1, clr, stop, state
  );
endinterface

// File: rtl/simplez_sequencer.sv
// simplez_sequencer: SIMPLEZ instruction-cycle FSM decoding micro-orders from state, opcode and z
module simplez_sequencer (
  input  logic                clk,
  input  logic                rst,
  simplez_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {I0 = 3'd0, I1 = 3'd1, O0 = 3'd2, O1 = 3'd3, HALT = 3'd4} state_t;
  state_t state_q, state_d;
  logic   br;
  // datapath registers update on the falling edge, so the sequencer does too
  always_ff @(negedge clk)
    state_q <= rst ? I0 : state_d;
  assign bus.state = rst ? 3'd0 : state_q;
  always_comb begin
    {bus.lec, bus.esc, bus.era, bus.incp, bus.ccp, bus.scp, bus.eri, bus.sri,
     bus.eac, bus.sac, bus.sum, bus.tra2, bus.dec1, bus.clr, bus.stop} = '0;
    state_d = I0;
    br = bus.co == 3'd3 || (bus.co == 3'd4 && bus.z);
    case (state_q)
      I0: begin
        bus.lec  = 1'b1;
        bus.eri  = 1'b1;
        bus.incp = 1'b1;
        state_d  = I1;
      end
      I1: begin
        bus.era  = 1'b1;
        bus.sri  = bus.co < 3'd3 || br;
        bus.scp  = !(bus.co < 3'd3 || br);
        bus.ccp  = br;
        bus.eac  = bus.co == 3'd5 || bus.co == 3'd6;
        bus.clr  = bus.co == 3'd5;
        bus.dec1 = bus.co == 3'd6;
        state_d  = bus.co < 3'd3 ? O0 : bus.co == 3'd7 ? HALT : I0;
      end
      O0: begin
        bus.sac  = bus.co == 3'd0;
        bus.esc  = bus.co == 3'd0;
        bus.lec  = bus.co == 3'd1 || bus.co == 3'd2;
        bus.eac  = bus.co == 3'd1 || bus.co == 3'd2;
        bus.tra2 = bus.co == 3'd1;
        bus.sum  = bus.co == 3'd2;
        state_d  = O1;
      end
      O1: begin
        bus.scp = 1'b1;
        bus.era = 1'b1;
      end
      HALT: begin
        bus.stop = 1'b1;
        state_d  = bus.cont ? I0 : HALT;
      end
      default: state_d = I0;
    endcase
    // reset suppresses every micro-order, aborting any in-flight write
    if (rst)
      {bus.lec, bus.esc, bus.era, bus.incp, bus.ccp, bus.scp, bus.eri, bus.sri,
       bus.eac, bus.sac, bus.sum, bus.tra2, bus.dec1, bus.clr, bus.stop} = '0;
  end
endmodule

// File: tb/tb_simplez_sequencer.sv
// tb_simplez_sequencer: instruction-level reference model checked against the sequencer each cycle
module tb_simplez_sequencer;
  localparam logic [14:0] LEC  = 15'h4000, ESC  = 15'h2000, ERA  = 15'h1000, INCP = 15'h0800,
                          CCP  = 15'h0400, SCP  = 15'h0200, ERI  = 15'h0100, SRI  = 15'h0080,
                          EAC  = 15'h0040, SAC  = 15'h0020, SUM  = 15'h0010, TRA2 = 15'h0008,
                          DEC1 = 15'h0004, CLR  = 15'h0002, STOP = 15'h0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  simplez_sequencer_if bus ();
  simplez_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [14:0] mo();
    return {bus.lec, bus.esc, bus.era, bus.incp, bus.ccp, bus.scp, bus.eri, bus.sri,
            bus.eac, bus.sac, bus.sum, bus.tra2, bus.dec1, bus.clr, bus.stop};
  endfunction

  // Expected per-cycle (state, micro-order set) for one whole instruction, from the ISA table
  task automatic model(input logic [2:0] c, input bit zz, input int hw,
                       output int es[$], output logic [14:0] em[$]);
    es = {0};
    em = {LEC | ERI | INCP};
    es.push_back(1);
    case (c)
      3'd0, 3'd1, 3'd2: begin
        em.push_back(SRI | ERA);
        es.push_back(2);
        em.push_back(c == 0 ? SAC | ESC : c == 1 ? LEC | EAC | TRA2 : LEC | EAC | SUM);
        es.push_back(3);
        em.push_back(SCP | ERA);
      end
      3'd3:    em.push_back(SRI | ERA | CCP);
      3'd4:    em.push_back(zz ? SRI | ERA | CCP : SCP | ERA);
      3'd5:    em.push_back(EAC | CLR | SCP | ERA);
      3'd6:    em.push_back(EAC | DEC1 | SCP | ERA);
      default: begin
        em.push_back(SCP | ERA);
        for (int h = 0; h <= hw; h++) begin
          es.push_back(4);
          em.push_back(STOP);
        end
      end
    endcase
  endtask

  task automatic run_instr(input string name, input logic [2:0] c, input bit zz, input int hw);
    int          es[$];
    logic [14:0] em[$];
    logic [3:0]  alu;
    int          h;
    model(c, zz, hw, es, em);
    h = 0;
    for (int i = 0; i < es.size(); i++) begin
      bus.co   = i == 0 ? 3'($urandom) : c;
      bus.z    = i == 1 ? zz : 1'($urandom);
      bus.cont = es[i] == 4 ? h == hw : 1'($urandom);
      if (es[i] == 4) h++;
      @(posedge clk);
      checks++;
      if (bus.state !== 3'(es[i]) || mo() !== em[i]) begin
        errors++;
        $display("FAIL %s cyc%0d: state=%0d mo=%h, expected state=%0d mo=%h",
                 name, i, bus.state, mo(), es[i], em[i]);
      end
      alu = {bus.sum, bus.tra2, bus.dec1, bus.clr};
      checks++;
      if ($countones(alu) > 1 || (alu != 0 && !bus.eac) || (bus.lec && bus.esc)) begin
        errors++;
        $display("FAIL %s invariant cyc%0d: alu=%b eac=%b lec=%b esc=%b, expected onehot0 alu gated by eac, no lec&esc",
                 name, i, alu, bus.eac, bus.lec, bus.esc);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.co = 3'd2;
    bus.cont = 1'b1;
    bus.z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      checks++;
      if (bus.state !== 3'd0 || mo() !== 15'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: state=%0d mo=%h, expected state=0 mo=0000", i, bus.state, mo());
      end
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    run_instr("reset_release_br", 3'd3, 1'b0, 0);
  endtask

  task automatic test_ld();
    run_instr("ld", 3'd1, 1'b0, 0);
  endtask

  task automatic test_st();
    run_instr("st", 3'd0, 1'b1, 0);
  endtask

  task automatic test_bz();
    run_instr("bz_taken", 3'd4, 1'b1, 0);
    run_instr("bz_not_taken", 3'd4, 1'b0, 0);
  endtask

  task automatic test_halt();
    run_instr("halt", 3'd7, 1'b0, 10);
    run_instr("after_halt_clr", 3'd5, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    bus.co = 3'($urandom);
    @(posedge clk);
    checks++;
    if (bus.state !== 3'd0 || mo() !== (LEC | ERI | INCP)) begin
      errors++;
      $display("FAIL reset_mid_i0: state=%0d mo=%h, expected state=0 mo=%h", bus.state, mo(), LEC | ERI | INCP);
    end
    @(negedge clk);
    #1;
    bus.co = 3'd0;
    @(posedge clk);
    checks++;
    if (bus.state !== 3'd1 || mo() !== (SRI | ERA)) begin
      errors++;
      $display("FAIL reset_mid_i1: state=%0d mo=%h, expected state=1 mo=%h", bus.state, mo(), SRI | ERA);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.cont = 1'b1;
    @(posedge clk);
    checks++;
    if (bus.state !== 3'd0 || mo() !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid_o0: state=%0d mo=%h esc=%b, expected state=0 mo=0000", bus.state, mo(), bus.esc);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    run_instr("reset_mid_resume", 3'd0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] prog[8] = '{3'd1, 3'd2, 3'd0, 3'd6, 3'd4, 3'd3, 3'd5, 3'd2};
    for (int i = 0; i < 8; i++) run_instr("b2b", prog[i], 1'(i & 1), 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_instr("random", 3'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 5)));
  endtask

  initial begin
    test_reset();
    test_ld();
    test_st();
    test_bz();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
